// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   ADDR_W / DATA_W / RESET_PC : default address width, instruction width and
//                                post-reset program counter.
//   fetch_state_t              : instruction fetch state, also used by CPU_FSM
//                                for debug visibility.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC select for the fetch stage.
//   pc          in  : current fetch PC
//   instr_pc    in  : address of the instruction held in the instruction register
//   branch_disp in  : signed 8-bit displacement, relative to instr_pc
//   jump_target in  : absolute target
//   inc_en      in  : advance PC by one (fetch capture)
//   branch_en   in  : PC-relative redirect
//   jump_en     in  : absolute redirect, wins over branch_en
//   next_pc     out : selected next PC (holds pc when nothing is enabled)
// Increment has top priority because the top only raises it in WAIT, where
// redirects are gated off anyway.
module instr_fetch_pc_next #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] instr_pc,
  input  logic [7:0]        branch_disp,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              inc_en,
  input  logic              branch_en,
  input  logic              jump_en,
  output logic [ADDR_W-1:0] next_pc
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic [ADDR_W-1:0] disp_ext;

  // Sign-extend the displacement; the add then wraps modulo 2^ADDR_W.
  assign disp_ext = {{(ADDR_W-8){branch_disp[7]}}, branch_disp};

  always_comb begin
    next_pc = pc;
    if (inc_en) begin
      next_pc = pc + ONE;
    end else if (jump_en) begin
      next_pc = jump_target;
    end else if (branch_en) begin
      next_pc = instr_pc + disp_ext;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage between PC/RAM and CPU_FSM.
//   Clk, Rst    : clock (rising edge), synchronous active-high reset
//   FetchReq    : request next instruction (accepted in IDLE/DONE, no redirect)
//   BranchEn/BranchDisp : PC <= InstrPC + sext(BranchDisp)
//   JumpEn/JumpTarget   : PC <= JumpTarget (wins over branch)
//   RAMData     : RAM port A read data, one cycle after RAMAddr
//   RAMAddr     : RAM port A address, equal to PC
//   Instr, InstrPC, PCPlus1 : instruction register, its address, address+1
//   InstrValid  : high for the single DONE cycle after a capture
//   Busy        : fetch in flight (WAIT)
//   DbgState    : current fetch state
// Handshake: FetchReq is a level request sampled every cycle; it is taken
// only in IDLE or DONE with no redirect pending, and the result is signalled
// by one InstrValid cycle two clocks later. A redirect never starts a fetch;
// the FSM re-requests afterwards. Redirects raised while Busy are ignored.
module instr_fetch #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  FetchReq,
  input  logic                  BranchEn,
  input  logic [7:0]            BranchDisp,
  input  logic                  JumpEn,
  input  logic [ADDR_W-1:0]     JumpTarget,
  input  logic [DATA_W-1:0]     RAMData,
  output logic [ADDR_W-1:0]     RAMAddr,
  output logic [DATA_W-1:0]     Instr,
  output logic                  InstrValid,
  output logic [ADDR_W-1:0]     InstrPC,
  output logic [ADDR_W-1:0]     PCPlus1,
  output logic                  Busy,
  output cpu_pkg::fetch_state_t DbgState
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] ONE = 1;

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_sel;
  logic              can_issue, redirect, accept, in_wait;

  assign in_wait   = (state == WAIT);
  assign can_issue = (state == IDLE) || (state == DONE);
  assign redirect  = can_issue && (BranchEn || JumpEn);
  assign accept    = can_issue && FetchReq && !BranchEn && !JumpEn;

  instr_fetch_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc          (pc),
    .instr_pc    (InstrPC),
    .branch_disp (BranchDisp),
    .jump_target (JumpTarget),
    .inc_en      (in_wait),
    .branch_en   (BranchEn && can_issue),
    .jump_en     (JumpEn && can_issue),
    .next_pc     (pc_sel)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    state_next = DONE;
      DONE:    state_next = accept ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      Instr   <= '0;
      InstrPC <= '0;
    end else begin
      state <= state_next;
      if (in_wait || redirect) pc <= pc_sel;
      // RAM data for the address issued last cycle is valid during WAIT.
      if (in_wait) begin
        Instr   <= RAMData;
        InstrPC <= pc;
      end
    end
  end

  assign RAMAddr    = pc;
  assign PCPlus1    = InstrPC + ONE;
  assign Busy       = in_wait;
  assign InstrValid = (state == DONE);
  assign DbgState   = state;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        FetchReq = 1'b0;
  logic        BranchEn = 1'b0;
  logic [7:0]  BranchDisp = 8'h00;
  logic        JumpEn = 1'b0;
  logic [15:0] JumpTarget = 16'h0000;
  logic [15:0] RAMData;
  logic [15:0] RAMAddr, Instr, InstrPC, PCPlus1;
  logic        InstrValid, Busy;
  fetch_state_t DbgState;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural PC and instruction register contents.
  logic [15:0] ram [0:65535];
  logic [15:0] m_pc, m_instr, m_ipc;

  instr_fetch dut (
    .Clk(Clk), .Rst(Rst), .FetchReq(FetchReq), .BranchEn(BranchEn),
    .BranchDisp(BranchDisp), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .RAMData(RAMData), .RAMAddr(RAMAddr), .Instr(Instr),
    .InstrValid(InstrValid), .InstrPC(InstrPC), .PCPlus1(PCPlus1),
    .Busy(Busy), .DbgState(DbgState)
  );

  always #5 Clk = ~Clk;

  // One-cycle read latency RAM port A.
  always @(posedge Clk) RAMData <= ram[RAMAddr];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] wrap(input int v);
    return 16'(v & 32'hFFFF);
  endfunction

  function automatic int sdisp(input logic [7:0] d);
    return (int'(d) > 127) ? int'(d) - 256 : int'(d);
  endfunction

  task automatic check_regs(input string name);
    vectors++;
    if (RAMAddr !== m_pc || Instr !== m_instr || InstrPC !== m_ipc ||
        PCPlus1 !== wrap(int'(m_ipc) + 1)) begin
      miscompares++;
      $display("FAIL %s: addr=%h instr=%h ipc=%h p1=%h, want addr=%h instr=%h ipc=%h p1=%h",
               name, RAMAddr, Instr, InstrPC, PCPlus1, m_pc, m_instr, m_ipc, wrap(int'(m_ipc) + 1));
    end
  endtask

  task automatic do_jump(input logic [15:0] t, input string name);
    JumpEn = 1'b1; JumpTarget = t; BranchDisp = 8'($urandom_range(0, 255));
    step();
    JumpEn = 1'b0;
    m_pc = t;
    check_regs(name);
    vectors++;
    if (Busy !== 1'b0 || DbgState !== IDLE) begin
      miscompares++;
      $display("FAIL %s_state: busy=%b state=%0d, want busy=0 state=IDLE", name, Busy, DbgState);
    end
  endtask

  task automatic do_branch(input logic [7:0] d, input string name);
    BranchEn = 1'b1; BranchDisp = d;
    step();
    BranchEn = 1'b0;
    m_pc = wrap(int'(m_ipc) + sdisp(d));
    check_regs(name);
  endtask

  // Single request pulse; ends back in IDLE.
  task automatic fetch_one(input string name);
    FetchReq = 1'b1;
    step();
    FetchReq = 1'b0;
    vectors++;
    if (Busy !== 1'b1 || InstrValid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_wait: busy=%b valid=%b, want busy=1 valid=0", name, Busy, InstrValid);
    end
    step();
    m_instr = ram[m_pc]; m_ipc = m_pc; m_pc = wrap(int'(m_pc) + 1);
    vectors++;
    if (InstrValid !== 1'b1 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_valid: valid=%b busy=%b, want valid=1 busy=0", name, InstrValid, Busy);
    end
    check_regs(name);
    step();
    vectors++;
    if (InstrValid !== 1'b0 || DbgState !== IDLE) begin
      miscompares++;
      $display("FAIL %s_after: valid=%b state=%0d, want valid=0 state=IDLE", name, InstrValid, DbgState);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step(); step();
    Rst = 1'b0;
    m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
    check_regs("reset_regs");
    vectors++;
    if (InstrValid !== 1'b0 || Busy !== 1'b0 || DbgState !== IDLE || PCPlus1 !== 16'h0001) begin
      miscompares++;
      $display("FAIL reset_ctrl: valid=%b busy=%b state=%0d p1=%h, want 0 0 IDLE 0001",
               InstrValid, Busy, DbgState, PCPlus1);
    end
  endtask

  task automatic test_single_fetch();
    ram[0] = 16'h5301;
    fetch_one("single_fetch");
    vectors++;
    if (Instr !== 16'h5301 || InstrPC !== 16'h0000 || RAMAddr !== 16'h0001) begin
      miscompares++;
      $display("FAIL single_fetch_const: instr=%h ipc=%h addr=%h, want 5301 0000 0001", Instr, InstrPC, RAMAddr);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_jump(16'h0000, "b2b_jump");
    FetchReq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (InstrValid !== (i % 2 == 1)) begin
        miscompares++;
        $display("FAIL b2b_pulse%0d: valid=%b, want %b", i, InstrValid, (i % 2 == 1));
      end
      if (i % 2 == 1) begin
        m_instr = ram[m_pc]; m_ipc = m_pc; m_pc = wrap(int'(m_pc) + 1);
        pulses++;
        check_regs("b2b_regs");
        vectors++;
        if (InstrPC !== 16'(pulses - 1) || PCPlus1 !== 16'(pulses)) begin
          miscompares++;
          $display("FAIL b2b_ipc: ipc=%h p1=%h, want %h %h", InstrPC, PCPlus1, 16'(pulses - 1), 16'(pulses));
        end
      end
    end
    FetchReq = 1'b0;
    step();
    vectors++;
    if (DbgState !== IDLE || InstrValid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: state=%0d valid=%b, want IDLE 0", DbgState, InstrValid);
    end
  endtask

  task automatic test_branch();
    do_jump(16'h0010, "br_jump");
    fetch_one("br_fetch");
    do_branch(8'hFC, "br_back");
    vectors++;
    if (RAMAddr !== 16'h000C) begin
      miscompares++;
      $display("FAIL br_back_const: addr=%h, want 000c", RAMAddr);
    end
    do_branch(8'h05, "br_fwd");
    vectors++;
    if (RAMAddr !== 16'h0015) begin
      miscompares++;
      $display("FAIL br_fwd_const: addr=%h, want 0015", RAMAddr);
    end
  endtask

  task automatic test_jump_priority();
    JumpEn = 1'b1; BranchEn = 1'b1; FetchReq = 1'b1;
    JumpTarget = 16'h0200; BranchDisp = 8'h33;
    step();
    JumpEn = 1'b0; BranchEn = 1'b0; FetchReq = 1'b0;
    m_pc = 16'h0200;
    check_regs("prio_jump");
    vectors++;
    if (Busy !== 1'b0 || DbgState !== IDLE) begin
      miscompares++;
      $display("FAIL prio_nofetch: busy=%b state=%0d, want 0 IDLE", Busy, DbgState);
    end
    fetch_one("prio_fetch");
  endtask

  task automatic test_wrap();
    do_jump(16'hFFFF, "wrap_jump");
    fetch_one("wrap_fetch");
    vectors++;
    if (InstrPC !== 16'hFFFF || RAMAddr !== 16'h0000 || PCPlus1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_inc: ipc=%h addr=%h p1=%h, want ffff 0000 0000", InstrPC, RAMAddr, PCPlus1);
    end
    do_jump(16'h0002, "wrap_jump2");
    fetch_one("wrap_fetch2");
    do_branch(8'hFD, "wrap_branch");
    vectors++;
    if (RAMAddr !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_branch_const: addr=%h, want ffff", RAMAddr);
    end
  endtask

  task automatic test_reset_in_wait();
    do_jump(16'h0030, "rst_jump");
    FetchReq = 1'b1;
    step();
    FetchReq = 1'b0;
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    m_pc = RESET_PC; m_instr = 16'h0000; m_ipc = 16'h0000;
    check_regs("rst_wait_regs");
    vectors++;
    if (DbgState !== IDLE || InstrValid !== 1'b0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait_ctrl: state=%0d valid=%b busy=%b, want IDLE 0 0", DbgState, InstrValid, Busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (InstrValid !== 1'b0 || Instr !== 16'h0000) begin
        miscompares++;
        $display("FAIL rst_wait_nopulse%0d: valid=%b instr=%h, want 0 0000", i, InstrValid, Instr);
      end
    end
  endtask

  task automatic test_redirect_in_wait();
    do_jump(16'h0040, "rw_jump");
    FetchReq = 1'b1;
    step();
    FetchReq = 1'b0;
    JumpEn = 1'b1; BranchEn = 1'b1; JumpTarget = 16'h1234; BranchDisp = 8'h70;
    step();
    JumpEn = 1'b0; BranchEn = 1'b0;
    m_instr = ram[16'h0040]; m_ipc = 16'h0040; m_pc = 16'h0041;
    check_regs("rw_ignored");
    vectors++;
    if (InstrValid !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_valid: valid=%b, want 1", InstrValid);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: fetch_one("rand_fetch");
        1: do_jump(16'($urandom_range(0, 65535)), "rand_jump");
        default: do_branch(8'($urandom_range(0, 255)), "rand_branch");
      endcase
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 16'($urandom_range(0, 65535));
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_reset_in_wait();
    test_redirect_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage between the program counter/RAM and `CPU_FSM`. It owns the fetch PC and the instruction register. On request it reads one 16-bit instruction from RAM port A, which has one cycle of read latency, and presents it to the FSM with a one-cycle valid pulse. It also applies PC-relative branch and absolute jump redirects commanded by the FSM.

## Interface
- `ADDR_W`, default 16: RAM address and PC width.
- `DATA_W`, default 16: instruction width.
- `RESET_PC`, default 16'h0000: PC value after reset.

- `Clk`  in  1: single clock, rising edge.
- `Rst`  in  1: synchronous, active-high reset.
- `FetchReq`  in  1: FSM requests the next instruction.
- `BranchEn`  in  1: PC-relative redirect.
- `BranchDisp`  in  8: signed displacement, relative to `InstrPC`.
- `JumpEn`  in  1: absolute redirect.
- `JumpTarget`  in  ADDR_W: absolute target address.
- `RAMData`  in  DATA_W: RAM `q_a_out`.
- `RAMAddr`  out  ADDR_W: RAM `addr_a`. Combinational copy of PC.
- `Instr`  out  DATA_W: instruction register.
- `InstrValid`  out  1: one-cycle pulse when `Instr` is newly loaded.
- `InstrPC`  out  ADDR_W: address of the instruction currently in `Instr`.
- `PCPlus1`  out  ADDR_W: `InstrPC` + 1, the link value for JAL.
- `Busy`  out  1: a fetch is in flight (state WAIT).

## Operation
- States:
  - IDLE: no fetch in flight.
  - WAIT: address has been issued; RAM data returns during this cycle.
  - DONE: instruction captured; `InstrValid`=1.
- Transitions:
  - IDLE to WAIT on an accepted `FetchReq`.
  - WAIT to DONE unconditionally.
  - DONE to WAIT on an accepted `FetchReq`, so back-to-back fetches are allowed.
  - DONE to IDLE otherwise.
- A `FetchReq` is accepted when the state is IDLE or DONE and neither `BranchEn` nor `JumpEn` is high.
- Capture at the WAIT to DONE edge: `Instr`<=`RAMData`, `InstrPC`<=PC, PC<=PC+1.
- Redirects are accepted only in IDLE or DONE.
  - `JumpEn`: PC<=`JumpTarget`.
  - `BranchEn`: PC<=`InstrPC` + sign-extended `BranchDisp`.
  - Both asserted: `JumpEn` wins.
  - A redirect asserted in the same cycle as `FetchReq` applies to the PC and the fetch is not accepted. The FSM re-requests on the next cycle.
  - A redirect asserted in WAIT is ignored, and PC advances normally. FSM contract: never assert a redirect while `Busy`=1.
- Arithmetic is modulo 2^ADDR_W. 16'hFFFF+1 wraps to 16'h0000. A negative displacement below 0 wraps to the top of memory.
- `Instr` and `InstrPC` hold their value until the next capture; redirects do not clear them.
- Reset values:
  - PC=`RESET_PC`, so `RAMAddr`=`RESET_PC`.
  - `Instr`=0 and `InstrPC`=0, so `PCPlus1`=1.
  - `InstrValid`=0, `Busy`=0, state IDLE.
- Reset in WAIT discards the in-flight RAM data; `Instr` is not loaded.

## Timing
- Cycle N: `FetchReq` is accepted in IDLE. `RAMAddr`=PC is sampled by the RAM at the end of cycle N.
- Cycle N+1 (WAIT): `RAMData` is valid and `Busy`=1. It is captured at the end of N+1.
- Cycle N+2 (DONE): `InstrValid`=1 and the new `Instr`/`InstrPC` are visible. `RAMAddr` already shows PC+1.
- Latency is 2 cycles from request to valid.
- Sustained throughput is one instruction per 2 cycles, with `FetchReq` held high.
- A redirect in cycle M is visible on `RAMAddr` in cycle M+1.
- `RAMAddr`, `PCPlus1` and `Busy` are combinational from registers. There are no input-to-output combinational paths.

## Structure
- Shared package `cpu_pkg` holds `ADDR_W`, `DATA_W`, `RESET_PC`, and the `fetch_state_t` enum {IDLE, WAIT, DONE}. The enum is reused by `CPU_FSM` for debug.
- One natural sub-module is `pc_next`, a combinational next-PC select. Inputs are PC, `InstrPC`, `BranchDisp`, `JumpTarget`, and the enables; it computes the increment/branch/jump result with jump priority. The FSM and the registers stay in `instr_fetch`.

## Test plan
- Reset, RAM[0]=16'h5301, then `FetchReq` for one cycle:
  - `Busy`=1 on cycle 2.
  - `InstrValid` pulses on cycle 3 with `Instr`=16'h5301 and `InstrPC`=0.
  - `RAMAddr`=1 afterwards.
- `FetchReq` held high for 6 cycles over RAM[0..2]:
  - Three valid pulses, 2 cycles apart.
  - `InstrPC`=0,1,2.
  - `PCPlus1`=1,2,3.
- After capturing `InstrPC`=16'h0010, pulse `BranchEn` with `BranchDisp`=8'hFC:
  - Next cycle `RAMAddr`=16'h000C.
  - Branch with `BranchDisp`=8'h05: `RAMAddr`=16'h0015.
- `JumpEn`=1 and `BranchEn`=1 together with `JumpTarget`=16'h0200, and `FetchReq` high in the same cycle:
  - `RAMAddr`=16'h0200 next cycle.
  - No fetch is started.
  - A following `FetchReq` fetches RAM[16'h0200].
- Jump to 16'hFFFF, then fetch: `InstrPC`=16'hFFFF and next `RAMAddr`=16'h0000. Then from `InstrPC`=16'h0002, branch with `BranchDisp`=8'hFD: `RAMAddr`=16'hFFFF.
- Assert `Rst` during WAIT:
  - Next cycle: state IDLE, `InstrValid`=0, `Busy`=0, `Instr`=0, `RAMAddr`=`RESET_PC`.
  - No valid pulse follows.
  - Redirect in WAIT is ignored: PC advances to +1.
